// File: rtl/fsm_mealy_seq_det_if.sv
// fsm_mealy_seq_det_if: symbol stream in, match/status out for the sequence detector
interface fsm_mealy_seq_det_if #(
    parameter int SYM_W   = 2,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int FILL_W = $clog2(PAT_LEN);
    logic              clear;
    logic              in_valid;
    logic [SYM_W-1:0]  in_sym;
    logic              match;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  match_cnt;
    logic              cnt_sat;
    modport master (output clear, in_valid, in_sym, input match, fill, match_cnt, cnt_sat);
    modport slave (input clear, in_valid, in_sym, output match, fill, match_cnt, cnt_sat);
endinterface

// File: rtl/fsm_mealy_seq_det.sv
// fsm_mealy_seq_det: parametrised Mealy sequence detector with saturating match counter
// Define FSM_MEALY_SEQ_DET_REG_OUT_EN to register match (one cycle later); default is combinational.
module fsm_mealy_seq_det #(
    parameter int                       SYM_W   = 2,
    parameter int                       PAT_LEN = 4,
    parameter logic [SYM_W*PAT_LEN-1:0] PATTERN = 8'b11_10_00_00,
    parameter int                       OVERLAP = 1,
    parameter int                       CNT_W   = 8
) (
    input logic clk,
    input logic rst,
    fsm_mealy_seq_det_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_LEN);
    localparam int HIST_W = SYM_W * (PAT_LEN - 1);
    localparam logic [FILL_W-1:0] TOP = FILL_W'(PAT_LEN - 1);

    logic [HIST_W-1:0]        hist;
    logic [FILL_W-1:0]        fill;
    logic [CNT_W-1:0]         cnt;
    logic                     sat;
    logic [SYM_W*PAT_LEN-1:0] window;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     accept;
    logic                     hit;

    assign window  = {hist, bus.in_sym};
    assign accept  = bus.in_valid & ~bus.clear;
    assign hit     = accept && (fill == TOP) && (window == PATTERN);
    assign cnt_inc = sat ? cnt : cnt + 1'b1;

`ifdef FSM_MEALY_SEQ_DET_REG_OUT_EN
    logic match_q;
    assign bus.match = match_q;
`else
    assign bus.match = hit;
`endif
    assign bus.fill      = fill;
    assign bus.match_cnt = cnt;
    assign bus.cnt_sat   = sat;

    // fill is the FSM state; history shift, restart on non-overlapping match, saturating count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            cnt  <= '0;
            sat  <= 1'b0;
`ifdef FSM_MEALY_SEQ_DET_REG_OUT_EN
            match_q <= 1'b0;
`endif
        end else begin
`ifdef FSM_MEALY_SEQ_DET_REG_OUT_EN
            match_q <= hit;
`endif
            if (bus.clear) begin
                fill <= '0;
                cnt  <= '0;
                sat  <= 1'b0;
            end else if (accept) begin
                hist <= window[HIST_W-1:0];
                fill <= (hit && OVERLAP == 0) ? '0 : (fill == TOP) ? fill : fill + 1'b1;
                if (hit) begin
                    cnt <= cnt_inc;
                    sat <= &cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_fsm_mealy_seq_det.sv
// tb_fsm_mealy_seq_det: four detector configurations driven by one stream, checked against a queue model
module tb_fsm_mealy_seq_det;
    logic       clk;
    logic       rst;
    logic       valid;
    logic       clr;
    logic [1:0] sym;
    int checks = 0;
    int errors = 0;

    int pat[4]  = '{8'hE0, 8'h55, 8'h55, 8'hE0};
    int ovl[4]  = '{1, 1, 0, 1};
    int cmax[4] = '{255, 255, 255, 3};
    int tbl[6]  = '{3, 2, 0, 0, 1, 1};
    int q[4][$];
    int cnt[4];
    logic emx[4];

    logic        m_o[4];
    logic [31:0] f_o[4];
    logic [31:0] c_o[4];
    logic        s_o[4];

    fsm_mealy_seq_det_if #(.CNT_W(8)) ia ();
    fsm_mealy_seq_det_if #(.CNT_W(8)) ib ();
    fsm_mealy_seq_det_if #(.CNT_W(8)) ic ();
    fsm_mealy_seq_det_if #(.CNT_W(2)) id ();

    fsm_mealy_seq_det #(.PATTERN(8'hE0), .OVERLAP(1), .CNT_W(8)) ua (.clk(clk), .rst(rst), .bus(ia));
    fsm_mealy_seq_det #(.PATTERN(8'h55), .OVERLAP(1), .CNT_W(8)) ub (.clk(clk), .rst(rst), .bus(ib));
    fsm_mealy_seq_det #(.PATTERN(8'h55), .OVERLAP(0), .CNT_W(8)) uc (.clk(clk), .rst(rst), .bus(ic));
    fsm_mealy_seq_det #(.PATTERN(8'hE0), .OVERLAP(1), .CNT_W(2)) ud (.clk(clk), .rst(rst), .bus(id));

    assign ia.in_valid = valid;
    assign ib.in_valid = valid;
    assign ic.in_valid = valid;
    assign id.in_valid = valid;
    assign ia.in_sym = sym;
    assign ib.in_sym = sym;
    assign ic.in_sym = sym;
    assign id.in_sym = sym;
    assign ia.clear = clr;
    assign ib.clear = clr;
    assign ic.clear = clr;
    assign id.clear = clr;

    assign m_o[0] = ia.match;
    assign m_o[1] = ib.match;
    assign m_o[2] = ic.match;
    assign m_o[3] = id.match;
    assign f_o[0] = 32'(ia.fill);
    assign f_o[1] = 32'(ib.fill);
    assign f_o[2] = 32'(ic.fill);
    assign f_o[3] = 32'(id.fill);
    assign c_o[0] = 32'(ia.match_cnt);
    assign c_o[1] = 32'(ib.match_cnt);
    assign c_o[2] = 32'(ic.match_cnt);
    assign c_o[3] = 32'(id.match_cnt);
    assign s_o[0] = ia.cnt_sat;
    assign s_o[1] = ib.cnt_sat;
    assign s_o[2] = ic.cnt_sat;
    assign s_o[3] = id.cnt_sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int psym(int k, int i);
        return (pat[k] >> (2 * (3 - i))) & 3;
    endfunction

    // pattern seen when the last three accepted symbols plus the current one spell it out
    function automatic logic emodel(int k);
        int n;
        n = q[k].size();
        if (!valid || clr || n < 3) return 1'b0;
        for (int i = 0; i < 3; i++)
            if (q[k][n-3+i] != psym(k, i)) return 1'b0;
        return int'(sym) == psym(k, 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            int f;
            emx[k] = emodel(k);
            f = q[k].size() > 3 ? 3 : q[k].size();
            chk($sformatf("match[%0d]", k), {31'b0, m_o[k]}, {31'b0, emx[k]});
            chk($sformatf("fill[%0d]", k), f_o[k], f);
            chk($sformatf("cnt[%0d]", k), c_o[k], cnt[k]);
            chk($sformatf("sat[%0d]", k), {31'b0, s_o[k]}, {31'b0, cnt[k] == cmax[k]});
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic c = 1'b0);
        valid = v;
        sym   = s;
        clr   = c;
        #4;
        check_all();
        for (int k = 0; k < 4; k++) begin
            if (clr) begin
                q[k].delete();
                cnt[k] = 0;
            end else if (valid) begin
                if (emx[k] && ovl[k] == 0) q[k].delete();
                else begin
                    q[k].push_back(int'(sym));
                    if (q[k].size() > 3) void'(q[k].pop_front());
                end
                if (emx[k] && cnt[k] < cmax[k]) cnt[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b0;
        valid = 1'b0;
        clr   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            cnt[k] = 0;
        end
        #1;
        check_all();
        repeat (n) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        int r;
        rst   = 1'b0;
        valid = 1'b0;
        clr   = 1'b0;
        sym   = 2'b00;
        @(posedge clk);
        #1;
        do_reset(5);
        repeat (3) step(1'b0, 2'b00);
        step(1'b1, 2'b11); step(1'b1, 2'b10); step(1'b1, 2'b00); step(1'b1, 2'b00);
        chk("t2_cnt", c_o[0], 1);
        do_reset(2);
        step(1'b1, 2'b11); step(1'b1, 2'b10); step(1'b1, 2'b00); step(1'b1, 2'b01);
        chk("t3_cnt", c_o[0], 0);
        chk("t3_fill", f_o[0], 3);
        do_reset(1);
        step(1'b1, 2'b11);
        repeat (3) step(1'b0, 2'b00);
        step(1'b1, 2'b10); step(1'b1, 2'b00); step(1'b0, 2'b00); step(1'b1, 2'b00);
        chk("t4_cnt", c_o[0], 1);
        do_reset(1);
        repeat (8) step(1'b1, 2'b01);
        chk("t5_ovl_cnt", c_o[1], 5);
        chk("t5_noovl_cnt", c_o[2], 2);
        do_reset(1);
        repeat (5) begin
            step(1'b1, 2'b11); step(1'b1, 2'b10); step(1'b1, 2'b00); step(1'b1, 2'b00);
        end
        chk("t6_cnt", c_o[3], 3);
        chk("t6_sat", {31'b0, s_o[3]}, 32'd1);
        step(1'b1, 2'b11, 1'b1);
        chk("t6_clr_cnt", c_o[3], 0);
        step(1'b1, 2'b11); step(1'b1, 2'b10); step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b00); step(1'b1, 2'b00);
        chk("t6_clr_nomatch", c_o[0], 0);
        step(1'b1, 2'b11); step(1'b1, 2'b10);
        do_reset(1);
        step(1'b1, 2'b00); step(1'b1, 2'b00);
        chk("t6_rst_nomatch", c_o[0], 0);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0) do_reset(1);
            else step(r < 75, 2'($unsigned(tbl[$urandom_range(0, 5)])), r >= 96);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
